// File: rtl/pc_fetch_gen_pkg.sv
// Shared constants and types for the fetch-address generator: reset vector,
// sequential step, legacy control-level constants and the FSM encoding.
package pc_fetch_gen_pkg;

    localparam logic [31:0] RESET_VECTOR_DEF = 32'hBFC0_0000;
    localparam int          PC_STEP_DEF      = 4;

    localparam logic RST_ENABLE = 1'b1;
    localparam logic BRANCH     = 1'b1;
    localparam logic NOT_STOP   = 1'b0;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/pc_redirect_hold.sv
// Holds a redirect that arrives while a fetch is in flight. A flush replaces
// any pending entry. A branch replaces a pending branch but never a pending flush.
module pc_redirect_hold
    import pc_fetch_gen_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              capture_i,
    input  logic              clear_i,
    input  logic              flush_i,
    input  logic [ADDR_W-1:0] flush_target_i,
    input  logic              branch_flag_i,
    input  logic [ADDR_W-1:0] branch_target_i,
    output logic              pend_valid_o,
    output logic [ADDR_W-1:0] pend_target_o
);

    logic pend_is_flush;
    logic take_flush;
    logic take_branch;

    assign take_flush  = capture_i & flush_i;
    assign take_branch = capture_i & ~flush_i & (branch_flag_i == BRANCH)
                       & ~(pend_valid_o & pend_is_flush);

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE || clear_i) begin
            pend_valid_o  <= 1'b0;
            pend_is_flush <= 1'b0;
        end else if (take_flush) begin
            pend_valid_o  <= 1'b1;
            pend_is_flush <= 1'b1;
        end else if (take_branch) begin
            pend_valid_o  <= 1'b1;
            pend_is_flush <= 1'b0;
        end
    end

    // NOTE: pend_target_o has no reset; it is only consumed while pend_valid_o is set.
    always_ff @(posedge clk) begin
        if (take_flush) begin
            pend_target_o <= flush_target_i;
        end else if (take_branch) begin
            pend_target_o <= branch_target_i;
        end
    end

endmodule

// File: rtl/pc_fetch_gen.sv
// Fetch-address generator with a req/ack instruction interface, flush/branch
// arbitration and stall handling. Define PC_FETCH_ALIGN_CHECK_EN for misaligned-PC trapping.
module pc_fetch_gen
    import pc_fetch_gen_pkg::*;
#(
    parameter int                ADDR_W       = 32,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(RESET_VECTOR_DEF),
    parameter int                PC_STEP      = PC_STEP_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic [ADDR_W-1:0] flush_target_i,
    input  logic              branch_flag_i,
    input  logic [ADDR_W-1:0] branch_target_i,
    output logic              inst_req_o,
    output logic [ADDR_W-1:0] inst_addr_o,
    input  logic              inst_ack_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic              pc_valid_o,
    output logic              adel_o
);

    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              outstanding_q;
    logic              squash_q;
    logic              accept, in_flight, redirect, pc_ok;
    logic              pc_valid_d, adel_fire;
    logic              pend_valid;
    logic [ADDR_W-1:0] pend_target;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: state_d gets its default first so no path through the case infers a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = RUN;
            RUN:     state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        inst_req_o  = outstanding_q | (state_q == RUN && stall_i == NOT_STOP && pc_ok);
        inst_addr_o = pc_q;
    end

    assign accept     = inst_req_o & inst_ack_i;
    assign in_flight  = inst_req_o & ~inst_ack_i;
    assign redirect   = flush_i | (branch_flag_i == BRANCH);
    assign pc_valid_d = accept & ~flush_i & ~squash_q;

    // A redirect with nothing in flight retargets pc_q at once; in flight it waits in the hold.
    always_comb begin
        pc_d = pc_q;
        if (accept) begin
            if (flush_i)                     pc_d = flush_target_i;
            else if (pend_valid)             pc_d = pend_target;
            else if (branch_flag_i == BRANCH) pc_d = branch_target_i;
            else                             pc_d = pc_q + STEP;
        end else if (!in_flight && redirect) begin
            pc_d = flush_i ? flush_target_i : branch_target_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            pc_q          <= RESET_VECTOR;
            outstanding_q <= 1'b0;
            squash_q      <= 1'b0;
            pc_o          <= '0;
            pc_valid_o    <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            outstanding_q <= in_flight;
            squash_q      <= in_flight & (squash_q | flush_i);
            pc_valid_o    <= pc_valid_d;
            if (pc_valid_d || adel_fire) begin
                pc_o <= pc_q;
            end
        end
    end

`ifdef PC_FETCH_ALIGN_CHECK_EN
    logic adel_seen_q;

    assign pc_ok     = (pc_q[1:0] == 2'b00);
    assign adel_fire = (state_q == RUN) & ~pc_ok & ~outstanding_q & ~adel_seen_q;

    // One adel_o pulse per misaligned pc_q; any new pc load re-arms the check.
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            adel_o      <= 1'b0;
            adel_seen_q <= 1'b0;
        end else begin
            adel_o <= adel_fire;
            if (accept || (!in_flight && redirect)) begin
                adel_seen_q <= 1'b0;
            end else if (adel_fire) begin
                adel_seen_q <= 1'b1;
            end
        end
    end
`else
    assign pc_ok     = 1'b1;
    assign adel_fire = 1'b0;
    assign adel_o    = 1'b0;
`endif

    pc_redirect_hold #(
        .ADDR_W(ADDR_W)
    ) u_redirect_hold (
        .clk             (clk),
        .rst             (rst),
        .capture_i       (in_flight),
        .clear_i         (accept),
        .flush_i         (flush_i),
        .flush_target_i  (flush_target_i),
        .branch_flag_i   (branch_flag_i),
        .branch_target_i (branch_target_i),
        .pend_valid_o    (pend_valid),
        .pend_target_o   (pend_target)
    );

endmodule

// File: tb/tb_pc_fetch_gen.sv
// Self-checking bench for pc_fetch_gen: directed handshake scenarios with a
// queue of expected returned PCs compared on each pc_valid_o cycle.
module tb_pc_fetch_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall_i = 1'b0;
    logic        flush_i = 1'b0;
    logic [31:0] flush_target_i = '0;
    logic        branch_flag_i = 1'b0;
    logic [31:0] branch_target_i = '0;
    logic        inst_ack_i = 1'b0;
    logic        inst_req_o;
    logic [31:0] inst_addr_o;
    logic [31:0] pc_o;
    logic        pc_valid_o;
    logic        adel_o;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] sb_q[$];
    bit          due = 1'b0;
    bit          adel_due = 1'b0;

    always #5 clk = ~clk;

    pc_fetch_gen dut (
        .clk             (clk),
        .rst             (rst),
        .stall_i         (stall_i),
        .flush_i         (flush_i),
        .flush_target_i  (flush_target_i),
        .branch_flag_i   (branch_flag_i),
        .branch_target_i (branch_target_i),
        .inst_req_o      (inst_req_o),
        .inst_addr_o     (inst_addr_o),
        .inst_ack_i      (inst_ack_i),
        .pc_o            (pc_o),
        .pc_valid_o      (pc_valid_o),
        .adel_o          (adel_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expect the fetch currently being accepted to return pc a on the next cycle.
    task automatic expect_pc(input logic [31:0] a);
        sb_q.push_back(a);
        due = 1'b1;
    endtask

    // Comb request/address check with the current inputs applied.
    task automatic exp_fetch(input bit r, input logic [31:0] a, input bit chk_addr);
        #1;
        check("inst_req", 32'(inst_req_o), 32'(r));
        if (chk_addr) check("inst_addr", inst_addr_o, a);
    endtask

    // Advance one clock, check the registered outputs, then drop one-cycle redirects.
    task automatic tick();
        bit d;
        bit ad;
        d        = due;
        ad       = adel_due;
        due      = 1'b0;
        adel_due = 1'b0;
        @(posedge clk);
        #1;
        check("pc_valid", 32'(pc_valid_o), 32'(d));
        if (d) check("pc_o", pc_o, sb_q.pop_front());
        check("adel", 32'(adel_o), 32'(ad));
        flush_i       = 1'b0;
        branch_flag_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        // Reset state
        tick();
        tick();
        check("rst_req", 32'(inst_req_o), 32'd0);
        check("rst_pc_o", pc_o, 32'h0);

        // Release with ack tied high: one dead cycle, then one PC per cycle
        rst        = 1'b0;
        inst_ack_i = 1'b1;
        exp_fetch(1'b0, '0, 1'b0);
        tick();
        for (int i = 0; i < 3; i++) begin
            exp_fetch(1'b1, 32'hBFC0_0000 + 32'(4 * i), 1'b1);
            expect_pc(32'hBFC0_0000 + 32'(4 * i));
            tick();
        end

        // Leave a fetch in flight with a pending branch, then reset mid-operation
        inst_ack_i = 1'b0;
        exp_fetch(1'b1, 32'hBFC0_000C, 1'b1);
        tick();
        branch_flag_i = 1'b1; branch_target_i = 32'h8000_0100;
        exp_fetch(1'b1, 32'hBFC0_000C, 1'b1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_fetch(1'b0, '0, 1'b0);
        tick();

        // ack low for 3 cycles, stall rises in the 2nd: request and address hold
        exp_fetch(1'b1, 32'hBFC0_0000, 1'b1);
        tick();
        stall_i = 1'b1;
        exp_fetch(1'b1, 32'hBFC0_0000, 1'b1);
        tick();
        exp_fetch(1'b1, 32'hBFC0_0000, 1'b1);
        tick();
        inst_ack_i = 1'b1;
        exp_fetch(1'b1, 32'hBFC0_0000, 1'b1);
        expect_pc(32'hBFC0_0000);
        tick();
        exp_fetch(1'b0, 32'hBFC0_0004, 1'b1);
        tick();
        inst_ack_i = 1'b0;
        exp_fetch(1'b0, 32'hBFC0_0004, 1'b1);
        tick();

        // Branch while BFC00004 is outstanding: it returns, then fetch the target
        stall_i = 1'b0;
        exp_fetch(1'b1, 32'hBFC0_0004, 1'b1);
        tick();
        branch_flag_i = 1'b1; branch_target_i = 32'h8000_0100;
        exp_fetch(1'b1, 32'hBFC0_0004, 1'b1);
        tick();
        inst_ack_i = 1'b1;
        exp_fetch(1'b1, 32'hBFC0_0004, 1'b1);
        expect_pc(32'hBFC0_0004);
        tick();
        inst_ack_i = 1'b0;
        exp_fetch(1'b1, 32'h8000_0100, 1'b1);
        tick();

        // Branch, flush, branch while outstanding: squashed return, flush target wins
        branch_flag_i = 1'b1; branch_target_i = 32'h8000_0200;
        exp_fetch(1'b1, 32'h8000_0100, 1'b1);
        tick();
        flush_i = 1'b1; flush_target_i = 32'hBFC0_0380;
        exp_fetch(1'b1, 32'h8000_0100, 1'b1);
        tick();
        branch_flag_i = 1'b1; branch_target_i = 32'h8000_0300;
        exp_fetch(1'b1, 32'h8000_0100, 1'b1);
        tick();
        inst_ack_i = 1'b1;
        exp_fetch(1'b1, 32'h8000_0100, 1'b1);
        tick();
        exp_fetch(1'b1, 32'hBFC0_0380, 1'b1);
        expect_pc(32'hBFC0_0380);
        tick();

        // Simultaneous flush and branch while stalled and idle: flush target loads directly
        stall_i = 1'b1; inst_ack_i = 1'b0;
        flush_i = 1'b1; flush_target_i = 32'hFFFF_FFFC;
        branch_flag_i = 1'b1; branch_target_i = 32'h8000_0000;
        exp_fetch(1'b0, 32'hBFC0_0384, 1'b1);
        tick();
        exp_fetch(1'b0, 32'hFFFF_FFFC, 1'b1);
        tick();

        // Sequential wrap FFFFFFFC -> 00000000 -> 00000004
        stall_i = 1'b0; inst_ack_i = 1'b1;
        exp_fetch(1'b1, 32'hFFFF_FFFC, 1'b1);
        expect_pc(32'hFFFF_FFFC);
        tick();
        exp_fetch(1'b1, 32'h0000_0000, 1'b1);
        expect_pc(32'h0000_0000);
        tick();
        stall_i = 1'b1;
        exp_fetch(1'b0, 32'h0000_0004, 1'b1);
        tick();

        // Flush in the same cycle as an accept suppresses that pc_valid_o
        stall_i = 1'b0;
        flush_i = 1'b1; flush_target_i = 32'hBFC0_0380;
        exp_fetch(1'b1, 32'h0000_0004, 1'b1);
        tick();
        exp_fetch(1'b1, 32'hBFC0_0380, 1'b1);
        expect_pc(32'hBFC0_0380);
        tick();

        // Branch while stalled with nothing in flight loads pc directly
        stall_i = 1'b1; inst_ack_i = 1'b0;
        branch_flag_i = 1'b1; branch_target_i = 32'h8000_0010;
        exp_fetch(1'b0, 32'hBFC0_0384, 1'b1);
        tick();
        exp_fetch(1'b0, 32'h8000_0010, 1'b1);
        tick();

        branch_flag_i = 1'b1; branch_target_i = 32'h8000_0102;
        tick();
`ifdef PC_FETCH_ALIGN_CHECK_EN
        // Misaligned target: no request, one adel_o pulse, resume on flush
        stall_i = 1'b0;
        exp_fetch(1'b0, 32'h8000_0102, 1'b1);
        adel_due = 1'b1;
        tick();
        check("adel_pc_o", pc_o, 32'h8000_0102);
        exp_fetch(1'b0, 32'h8000_0102, 1'b1);
        tick();
        inst_ack_i = 1'b1;
        flush_i = 1'b1; flush_target_i = 32'hBFC0_0380;
        exp_fetch(1'b0, 32'h8000_0102, 1'b1);
        tick();
        exp_fetch(1'b1, 32'hBFC0_0380, 1'b1);
        expect_pc(32'hBFC0_0380);
        tick();
`else
        // Without the check the misaligned address is fetched as-is
        stall_i = 1'b0; inst_ack_i = 1'b1;
        exp_fetch(1'b1, 32'h8000_0102, 1'b1);
        expect_pc(32'h8000_0102);
        tick();
        stall_i = 1'b1; inst_ack_i = 1'b0;
        exp_fetch(1'b0, 32'h8000_0106, 1'b1);
        tick();
`endif

        stall_i = 1'b1; inst_ack_i = 1'b0;
        tick();
        check("sb_drain", 32'(sb_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
